// File: rtl/vector_mem_responder_pkg.sv
// rtl/vector_mem_responder_pkg.sv - shared constants, lane vector type and FSM states for the vector memory responder
package vmem_pkg;

  localparam int DW    = 18;
  localparam int AW    = 10;
  localparam int LANES = 3;

  typedef logic [LANES-1:0][DW-1:0] lane_vec_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L0   = 3'd1,
    L1   = 3'd2,
    L2   = 3'd3,
    CAP  = 3'd4
  } state_t;

endpackage

// File: rtl/vector_mem_responder_if.sv
// rtl/vector_mem_responder_if.sv - pipeline memory-stage request/response bundle
interface vector_mem_responder_if #(
  parameter int DW    = vmem_pkg::DW,
  parameter int AW    = vmem_pkg::AW,
  parameter int LANES = vmem_pkg::LANES
);

  logic                      ReqM;
  logic                      MemWriteM;
  logic [AW-1:0]             A1M;
  logic [AW-1:0]             A2M;
  logic [AW-1:0]             A3M;
  logic [LANES-1:0][DW-1:0]  writeDataM;
  logic [LANES-1:0][DW-1:0]  RDE;
  logic                      RdValid;
  logic                      Done;
  logic                      Stall;

  // pipeline side: issues requests, consumes load data and hold
  modport master (
    output ReqM, MemWriteM, A1M, A2M, A3M, writeDataM,
    input  RDE, RdValid, Done, Stall
  );

  // responder side
  modport slave (
    input  ReqM, MemWriteM, A1M, A2M, A3M, writeDataM,
    output RDE, RdValid, Done, Stall
  );

endinterface

// File: rtl/vector_mem_responder_sp_ram.sv
// rtl/vector_mem_responder_sp_ram.sv - single-port RAM, synchronous read, read returns the pre-write word
module sp_ram #(
  parameter int DW = vmem_pkg::DW,
  parameter int AW = vmem_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // write on we, registered read of the addressed word (contents survive reset)
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vector_mem_responder.sv
// rtl/vector_mem_responder.sv - serialises a 3-lane vector load/store onto one single-port RAM
module vector_mem_responder #(
  parameter int DW    = vmem_pkg::DW,
  parameter int AW    = vmem_pkg::AW,
  parameter int LANES = vmem_pkg::LANES
) (
  input  logic                  CLK,
  input  logic                  RST,
  vector_mem_responder_if.slave bus
);

  import vmem_pkg::*;

  state_t state;
  state_t state_nx;

  logic                     wr_q;
  logic [AW-1:0]            a0_q;
  logic [AW-1:0]            a1_q;
  logic [AW-1:0]            a2_q;
  logic [LANES-1:0][DW-1:0] wd_q;
  logic [LANES-1:0][DW-1:0] rde_q;
  logic [LANES-1:0][DW-1:0] rde_cap;
  logic [DW-1:0]            cap0_q;
  logic [DW-1:0]            cap1_q;

  logic                     ram_we;
  logic [AW-1:0]            ram_addr;
  logic [DW-1:0]            ram_wdata;
  logic [DW-1:0]            ram_rdata;

  logic                     accept;

  assign accept = (state == IDLE) && bus.ReqM;

  sp_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state: accept only in IDLE, then walk the lanes unconditionally
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.ReqM ? L0 : IDLE;
      L0:      state_nx = L1;
      L1:      state_nx = L2;
      L2:      state_nx = CAP;
      CAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // request latch: addresses, store data and direction held for the whole service
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_q <= 1'b0;
      a0_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
      wd_q <= '0;
    end else if (accept) begin
      wr_q <= bus.MemWriteM;
      a0_q <= bus.A1M;
      a1_q <= bus.A2M;
      a2_q <= bus.A3M;
      wd_q <= bus.writeDataM;
    end
  end

  // load capture: RAM data lags the address by one cycle, so lane n lands one state later
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cap0_q <= '0;
      cap1_q <= '0;
      rde_q  <= '0;
    end else begin
      case (state)
        L1:      cap0_q <= ram_rdata;
        L2:      cap1_q <= ram_rdata;
        CAP:     if (!wr_q) rde_q <= rde_cap;
        default: ;
      endcase
    end
  end

  // assembled load result; lane 2 comes straight from the RAM during CAP
  always_comb begin
    rde_cap    = rde_q;
    rde_cap[0] = cap0_q;
    rde_cap[1] = cap1_q;
    rde_cap[2] = ram_rdata;
  end

  // outputs and RAM drive; write enable is gated by RST so a lane in flight at reset is not committed
  always_comb begin
    ram_we      = 1'b0;
    ram_addr    = a0_q;
    ram_wdata   = wd_q[0];
    bus.Done    = 1'b0;
    bus.RdValid = 1'b0;
    bus.Stall   = 1'b0;
    bus.RDE     = rde_q;
    case (state)
      IDLE: begin
        bus.Stall = bus.ReqM;
      end
      L0: begin
        ram_addr  = a0_q;
        ram_wdata = wd_q[0];
        ram_we    = wr_q && RST;
        bus.Stall = 1'b1;
      end
      L1: begin
        ram_addr  = a1_q;
        ram_wdata = wd_q[1];
        ram_we    = wr_q && RST;
        bus.Stall = 1'b1;
      end
      L2: begin
        ram_addr  = a2_q;
        ram_wdata = wd_q[2];
        ram_we    = wr_q && RST;
        bus.Stall = 1'b1;
      end
      CAP: begin
        bus.Done = 1'b1;
        if (!wr_q) begin
          bus.RdValid = 1'b1;
          bus.RDE     = rde_cap;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vector_mem_responder.sv
// tb/tb_vector_mem_responder.sv - directed self-checking bench for vector_mem_responder
module tb_vector_mem_responder;

  localparam int DW    = 18;
  localparam int AW    = 10;
  localparam int LANES = 3;

  typedef logic [LANES-1:0][DW-1:0] vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   total = 0;
  int   bad   = 0;

  vector_mem_responder_if #(.DW(DW), .AW(AW), .LANES(LANES)) bus ();

  vector_mem_responder #(.DW(DW), .AW(AW), .LANES(LANES)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    vec_t v;
    v[0] = d0;
    v[1] = d1;
    v[2] = d2;
    return v;
  endfunction

  // one request from an idle responder; checks hold, pulse and latency on the way
  task automatic do_req(input logic wr, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input vec_t wd, output vec_t rd);
    int lat;
    @(negedge CLK);
    bus.ReqM       = 1'b1;
    bus.MemWriteM  = wr;
    bus.A1M        = a0;
    bus.A2M        = a1;
    bus.A3M        = a2;
    bus.writeDataM = wd;
    @(posedge CLK);
    @(negedge CLK);
    bus.ReqM = 1'b0;
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) @(negedge CLK);
      if (bus.Done === 1'b1) begin
        lat = n;
        rd  = bus.RDE;
        total++;
        if (bus.RdValid !== !wr) begin
          bad++;
          $display("FAIL rdvalid_at_done: got %b want %b", bus.RdValid, !wr);
        end
        total++;
        if (bus.Stall !== 1'b0) begin
          bad++;
          $display("FAIL stall_at_done: got %b want 0", bus.Stall);
        end
        break;
      end
      total++;
      if (bus.Stall !== 1'b1 || bus.RdValid !== 1'b0) begin
        bad++;
        $display("FAIL busy_outputs cycle %0d: stall=%b rdvalid=%b want stall=1 rdvalid=0", n, bus.Stall, bus.RdValid);
      end
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL done_latency: got %0d want 4 (0 = no Done within bound)", lat);
    end
  endtask

  task automatic test_reset();
    RST            = 1'b0;
    bus.ReqM       = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.A1M        = '0;
    bus.A2M        = '0;
    bus.A3M        = '0;
    bus.writeDataM = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (bus.RDE !== '0) begin bad++; $display("FAIL reset_rde: got %h want 0", bus.RDE); end
    total++;
    if (bus.RdValid !== 1'b0 || bus.Done !== 1'b0) begin
      bad++; $display("FAIL reset_pulses: rdvalid=%b done=%b want 0 0", bus.RdValid, bus.Done);
    end
    total++;
    if (bus.Stall !== 1'b0) begin bad++; $display("FAIL reset_stall_idle: got %b want 0", bus.Stall); end
    bus.ReqM = 1'b1;
    #1;
    total++;
    if (bus.Stall !== 1'b1) begin bad++; $display("FAIL reset_stall_follows_req: got %b want 1", bus.Stall); end
    bus.ReqM = 1'b0;
    RST = 1'b1;
  endtask

  task automatic test_store_load();
    vec_t rd;
    do_req(1'b1, 10'd10, 10'd11, 10'd9, mk(18'h00001, 18'h3FFFF, 18'h12345), rd);
    do_req(1'b0, 10'd10, 10'd11, 10'd9, '0, rd);
    total++;
    if (rd !== mk(18'h00001, 18'h3FFFF, 18'h12345)) begin
      bad++; $display("FAIL store_load_rde: got %h want %h", rd, mk(18'h00001, 18'h3FFFF, 18'h12345));
    end
  endtask

  task automatic test_duplicates();
    vec_t rd;
    do_req(1'b1, 10'd6, 10'd4, 10'd7, mk(18'h66, 18'h44, 18'h77), rd);
    do_req(1'b1, 10'd5, 10'd5, 10'd5, mk(18'd1, 18'd2, 18'd3), rd);
    do_req(1'b0, 10'd5, 10'd6, 10'd4, '0, rd);
    total++;
    if (rd !== mk(18'd3, 18'h66, 18'h44)) begin
      bad++; $display("FAIL dup_store_last_lane: got %h want %h", rd, mk(18'd3, 18'h66, 18'h44));
    end
    do_req(1'b0, 10'd5, 10'd5, 10'd5, '0, rd);
    total++;
    if (rd !== mk(18'd3, 18'd3, 18'd3)) begin
      bad++; $display("FAIL dup_load_same_word: got %h want %h", rd, mk(18'd3, 18'd3, 18'd3));
    end
  endtask

  task automatic test_wrap();
    vec_t rd;
    do_req(1'b1, 10'd1023, 10'd0, 10'd1022, mk(18'd7, 18'd8, 18'd9), rd);
    do_req(1'b0, 10'd1023, 10'd0, 10'd1022, '0, rd);
    total++;
    if (rd !== mk(18'd7, 18'd8, 18'd9)) begin
      bad++; $display("FAIL wrap_rde: got %h want %h", rd, mk(18'd7, 18'd8, 18'd9));
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    vec_t rd;
    @(negedge CLK);
    bus.ReqM       = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.A1M        = 10'd50;
    bus.A2M        = 10'd51;
    bus.A3M        = 10'd52;
    bus.writeDataM = mk(18'h0A, 18'h0B, 18'h0C);
    @(posedge CLK);
    @(negedge CLK);
    bus.ReqM = 1'b0;
    @(negedge CLK);
    // second request (a load of the same lanes) arrives while busy
    bus.ReqM      = 1'b1;
    bus.MemWriteM = 1'b0;
    bus.writeDataM = mk(18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
    total++;
    if (bus.Stall !== 1'b1) begin bad++; $display("FAIL busy_stall_l1: got %b want 1", bus.Stall); end
    @(negedge CLK);
    total++;
    if (bus.Stall !== 1'b1 || bus.Done !== 1'b0) begin
      bad++; $display("FAIL busy_stall_l2: stall=%b done=%b want 1 0", bus.Stall, bus.Done);
    end
    @(negedge CLK);
    total++;
    if (bus.Done !== 1'b1 || bus.Stall !== 1'b0) begin
      bad++; $display("FAIL first_done: done=%b stall=%b want 1 0", bus.Done, bus.Stall);
    end
    @(negedge CLK);
    total++;
    if (bus.Stall !== 1'b1 || bus.Done !== 1'b0) begin
      bad++; $display("FAIL idle_pending_stall: stall=%b done=%b want 1 0", bus.Stall, bus.Done);
    end
    @(negedge CLK);
    bus.ReqM = 1'b0;
    gap = 0;
    rd  = '0;
    for (int k = 2; k <= 12; k++) begin
      if (k > 2) @(negedge CLK);
      if (bus.Done === 1'b1) begin
        gap = k;
        rd  = bus.RDE;
        break;
      end
    end
    total++;
    if (gap !== 5) begin bad++; $display("FAIL done_spacing: got %0d want 5 (0 = no Done within bound)", gap); end
    total++;
    if (rd !== mk(18'h0A, 18'h0B, 18'h0C)) begin
      bad++; $display("FAIL queued_load_rde: got %h want %h", rd, mk(18'h0A, 18'h0B, 18'h0C));
    end
  endtask

  task automatic test_reset_abort();
    vec_t rd;
    logic seen;
    do_req(1'b1, 10'd20, 10'd21, 10'd22, mk(18'd0, 18'd0, 18'd0), rd);
    @(negedge CLK);
    bus.ReqM       = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.A1M        = 10'd20;
    bus.A2M        = 10'd21;
    bus.A3M        = 10'd22;
    bus.writeDataM = mk(18'd1, 18'd2, 18'd3);
    @(posedge CLK);
    @(negedge CLK);
    bus.ReqM = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.Done !== 1'b0 || bus.RdValid !== 1'b0) seen = 1'b1;
      @(negedge CLK);
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got pulse=%b want 0", seen); end
    total++;
    if (bus.RDE !== '0) begin bad++; $display("FAIL abort_rde_cleared: got %h want 0", bus.RDE); end
    do_req(1'b0, 10'd20, 10'd21, 10'd22, '0, rd);
    total++;
    if (rd !== mk(18'd1, 18'd0, 18'd0)) begin
      bad++; $display("FAIL abort_partial_commit: got %h want %h", rd, mk(18'd1, 18'd0, 18'd0));
    end
  endtask

  task automatic test_rde_hold();
    vec_t rd;
    do_req(1'b1, 10'd30, 10'd31, 10'd32, mk(18'd4, 18'd5, 18'd6), rd);
    do_req(1'b0, 10'd30, 10'd31, 10'd32, '0, rd);
    total++;
    if (rd !== mk(18'd4, 18'd5, 18'd6)) begin
      bad++; $display("FAIL hold_load: got %h want %h", rd, mk(18'd4, 18'd5, 18'd6));
    end
    do_req(1'b1, 10'd40, 10'd41, 10'd42, mk(18'd9, 18'd9, 18'd9), rd);
    total++;
    if (rd !== mk(18'd4, 18'd5, 18'd6)) begin
      bad++; $display("FAIL hold_through_store: got %h want %h", rd, mk(18'd4, 18'd5, 18'd6));
    end
    repeat (3) @(negedge CLK);
    total++;
    if (bus.RDE !== mk(18'd4, 18'd5, 18'd6) || bus.RdValid !== 1'b0) begin
      bad++; $display("FAIL hold_idle: rde=%h rdvalid=%b want %h 0", bus.RDE, bus.RdValid, mk(18'd4, 18'd5, 18'd6));
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_duplicates();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    test_rde_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_mem_responder.md
VECTOR_MEM_RESPONDER -- requirements
Module: vector_mem_responder

Interface
REQ-001 Parameter DW, default 18: lane data width in bits.
REQ-002 Parameter AW, default 10: word address width; memory depth SHALL be 2**AW words.
REQ-003 Parameter LANES, default 3: lanes per vector request.
REQ-004 CLK  input  1: single clock; all state updates on rising edge.
REQ-005 RST  input  1: reset, synchronous, active-low.
REQ-006 ReqM  input  1: request valid from the pipeline memory stage.
REQ-007 MemWriteM  input  1: 1 = store of all lanes, 0 = load of all lanes; sampled with ReqM.
REQ-008 A1M, A2M, A3M  input  AW each: lane 0/1/2 word addresses.
REQ-009 writeDataM  input  LANES x DW: store data; lane i goes to address Ai+1M.
REQ-010 RDE  output  LANES x DW: load data returned to the pipeline.
REQ-011 RdValid  output  1: one-cycle pulse; RDE updated with a completed load.
REQ-012 Done  output  1: one-cycle pulse at completion of any accepted request.
REQ-013 Stall  output  1: pipeline hold; high while a request is pending or in service.

Function
REQ-014 Backing store SHALL be one single-port RAM, 2**AW x DW, with a synchronous read (data valid one cycle after address).
REQ-015 FSM states SHALL be IDLE, L0, L1, L2, CAP.
REQ-016 In IDLE with ReqM=1: latch addresses, data and MemWriteM; next state L0.
REQ-017 L0/L1/L2 SHALL drive lane 0/1/2 address to the RAM, with write enable equal to the latched MemWriteM; advance L0->L1->L2->CAP unconditionally.
REQ-018 Loads: lane 0 data captured in L1, lane 1 in L2, lane 2 in CAP.
REQ-019 CAP: for a load, drive RDE with all captured lanes and pulse RdValid; for any request, pulse Done; next state IDLE.
REQ-020 Latency: Done/RdValid SHALL be high exactly 4 cycles after the accept cycle; throughput is one request per 5 cycles.
REQ-021 Stall = ReqM in IDLE, or state != IDLE and state != CAP; Stall SHALL be low in CAP so the pipeline advances on the Done cycle.
REQ-022 ReqM while the FSM is not IDLE SHALL be ignored; the requester holds its request under Stall.
REQ-023 Store lanes commit in order 0,1,2; on duplicate addresses the highest-numbered lane's data SHALL persist.
REQ-024 A load with duplicate addresses SHALL return the same word on each duplicate lane.
REQ-025 Addresses are used modulo 2**AW, with no range check; 1023 and 0 are ordinary addresses.
REQ-026 RDE SHALL hold its last loaded value through stores and idle cycles.

Reset
REQ-027 RST=0 at a clock edge: state IDLE, RDE=0, RdValid=0, Done=0, latched request cleared; Stall then follows ReqM.
REQ-028 Reset during L0-CAP SHALL abort the request: no Done, no RdValid. Store lanes already written SHALL remain written; remaining lanes SHALL not be written.
REQ-029 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-030 Shared package vmem_pkg: DW, AW, LANES constants; lane-vector typedef (LANES x DW); FSM state enum.
REQ-031 Exactly one sub-module, sp_ram (single-port, synchronous read, write-first not required), instantiated once.

Verification
REQ-032 Store A=(10,11,9), data=(0x00001,0x3FFFF,0x12345); then load the same addresses -> RDE=(0x00001,0x3FFFF,0x12345), RdValid 4 cycles after the load is accepted.
REQ-033 Store A=(5,5,5), data=(1,2,3); load (5,6,4) -> lane0 = 3.
REQ-034 Wrap: store A=(1023,0,1022), data=(7,8,9); load the same -> (7,8,9).
REQ-035 Second request asserted 2 cycles after the first is accepted -> ignored while busy; Stall high; served after CAP, with Done spacing of 5 cycles.
REQ-036 RST low during L1 of a store to (20,21,22) with data (1,2,3), over previous contents (0,0,0) -> no Done; load returns (1,0,0), since only lane 0 committed.
REQ-037 After a load returns (4,5,6), issue a store -> RDE stays (4,5,6) and RdValid stays 0.
